assert_report_sched: RTL and testbench

ASSERT_REPORT_SCHED -- requirements
Module: assert_report_sched

---
 rtl/assert_report_pkg.sv | 32 +++
 rtl/assert_rr_pick.sv | 44 ++++
 rtl/assert_report_sched.sv | 162 ++++++++++++++++
 tb/tb_assert_report_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assert_report_pkg.sv
`default_nettype none
// ============================================================================
// Module      : assert_report_pkg
// Description : Shared constants, FSM state type and helpers for the
//               assertion report scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package assert_report_pkg;

    localparam int c_NUM_SRC_DFLT  = 8;
    localparam int c_CNT_W_DFLT    = 16;
    localparam int c_STOP_DLY_DFLT = 4;
    localparam int c_STOP_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Sources are capped at 32, so a fixed 32-bit popcount covers every build.
    function automatic logic [5:0] f_popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/assert_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : assert_rr_pick
// Description : Combinational round-robin picker; the search starts one past
//               the last granted index and wraps at NUM_SRC-1.
// Revision    : 1.0 - initial release
// ============================================================================
module assert_rr_pick #(
    parameter int NUM_SRC = 8,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_found;

    always_comb begin
        gnt        = '0;
        idx        = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        // Offsets 1..NUM_SRC visit every source once, the last granted one last.
        for (int off = 1; off <= NUM_SRC; off++) begin
            w_cand = int'(last) + off;
            if (w_cand >= NUM_SRC) begin
                w_cand = w_cand - NUM_SRC;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                gnt[w_cand_idx] = 1'b1;
                idx             = w_cand_idx;
                w_found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/assert_report_sched.sv
`default_nettype none
// ============================================================================
// Module      : assert_report_sched
// Description : Collects assertion-monitor fires, timestamps them, reports
//               them one at a time over valid/ready and requests a stop.
// Revision    : 1.0 - initial release
// ============================================================================
module assert_report_sched
    import assert_report_pkg::*;
#(
    parameter int NUM_SRC  = c_NUM_SRC_DFLT,
    parameter int CNT_W    = c_CNT_W_DFLT,
    parameter int STOP_DLY = c_STOP_DLY_DFLT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         fire_i,
    input  logic [NUM_SRC-1:0]         mask_i,
    output logic                       rpt_valid_o,
    input  logic                       rpt_ready_i,
    output logic [$clog2(NUM_SRC)-1:0] rpt_src_o,
    output logic [CNT_W-1:0]           rpt_cycle_o,
    output logic [NUM_SRC-1:0]         pend_o,
    output logic [CNT_W-1:0]           err_cnt_o,
    output logic                       ovf_o,
    output logic                       stop_o
);

    localparam int c_IDX_W = $clog2(NUM_SRC);

    logic [CNT_W-1:0]        r_cyc;
    logic [NUM_SRC-1:0]      r_pend;
    logic [CNT_W-1:0]        r_ts [NUM_SRC];
    logic [c_IDX_W-1:0]      r_ptr;
    logic                    r_valid;
    logic [c_IDX_W-1:0]      r_src;
    logic [CNT_W-1:0]        r_cycle;
    logic [CNT_W-1:0]        r_err;
    logic                    r_ovf;
    state_t                  r_state;
    logic [c_STOP_CNT_W-1:0] r_stop_cnt;
    logic                    r_stop;

    logic [NUM_SRC-1:0]      w_fire;
    logic [NUM_SRC-1:0]      w_gnt;
    logic [c_IDX_W-1:0]      w_gnt_idx;
    logic                    w_hs;
    logic                    w_slot_free;
    logic                    w_do_grant;
    logic [NUM_SRC-1:0]      w_clr;
    logic [NUM_SRC-1:0]      w_acc;
    logic                    w_ovf_hit;
    logic [31:0]             w_acc_ext;
    logic [5:0]              w_pop;
    logic [CNT_W:0]          w_err_sum;
    logic [CNT_W-1:0]        w_err_sat;

    assert_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .req  (r_pend),
        .last (r_ptr),
        .gnt  (w_gnt),
        .idx  (w_gnt_idx)
    );

    assign w_fire      = fire_i & mask_i;
    assign w_hs        = r_valid & rpt_ready_i;
    // The slot frees up in the same cycle it is consumed, allowing back-to-back reports.
    assign w_slot_free = ~r_valid | rpt_ready_i;
    assign w_do_grant  = w_slot_free & (|r_pend);
    assign w_clr       = w_do_grant ? w_gnt : '0;

    // A fire landing on the bit being granted away starts a fresh pending entry.
    assign w_acc     = w_fire & (~r_pend | w_clr);
    assign w_ovf_hit = |(w_fire & r_pend & ~w_clr);

    assign w_acc_ext = 32'(w_acc);
    assign w_pop     = f_popcount32(w_acc_ext);
    assign w_err_sum = {1'b0, r_err} + (CNT_W + 1)'(w_pop);
    assign w_err_sat = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cyc   <= '0;
            r_pend  <= '0;
            r_ptr   <= c_IDX_W'(NUM_SRC - 1);
            r_valid <= 1'b0;
            r_src   <= '0;
            r_cycle <= '0;
            r_err   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_cyc  <= r_cyc + CNT_W'(1);
            r_pend <= (r_pend & ~w_clr) | w_acc;
            r_err  <= w_err_sat;
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
            if (w_do_grant) begin
                r_valid <= 1'b1;
                r_src   <= w_gnt_idx;
                r_cycle <= r_ts[w_gnt_idx];
                r_ptr   <= w_gnt_idx;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ts
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_ts[i] <= '0;
            end else if (w_acc[i]) begin
                r_ts[i] <= r_cyc;
            end
        end
    end

    // Stop sequencing: countdown starts at the first consumed report; HALT is terminal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_stop_cnt <= '0;
            r_stop     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hs) begin
                        r_state    <= ST_DRAIN;
                        r_stop_cnt <= c_STOP_CNT_W'(STOP_DLY);
                    end
                end
                ST_DRAIN: begin
                    r_stop_cnt <= r_stop_cnt - c_STOP_CNT_W'(1);
                    if (r_stop_cnt <= c_STOP_CNT_W'(1)) begin
                        r_state <= ST_HALT;
                        r_stop  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_stop <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign rpt_valid_o = r_valid;
    assign rpt_src_o   = r_src;
    assign rpt_cycle_o = r_cycle;
    assign pend_o      = r_pend;
    assign err_cnt_o   = r_err;
    assign ovf_o       = r_ovf;
    assign stop_o      = r_stop;

endmodule
`default_nettype wire

// File: tb/tb_assert_report_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_assert_report_sched
// Description : Self-checking bench: vector table plus directed sequences,
//               with a report scoreboard checked on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assert_report_sched;

    localparam int NS = 8;
    localparam int CW = 16;
    localparam int SD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NS-1:0] fire_i;
    logic [NS-1:0] mask_i;
    logic          rpt_valid_o;
    logic          rpt_ready_i;
    logic [2:0]    rpt_src_o;
    logic [CW-1:0] rpt_cycle_o;
    logic [NS-1:0] pend_o;
    logic [CW-1:0] err_cnt_o;
    logic          ovf_o;
    logic          stop_o;

    assert_report_sched #(
        .NUM_SRC  (NS),
        .CNT_W    (CW),
        .STOP_DLY (SD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fire_i      (fire_i),
        .mask_i      (mask_i),
        .rpt_valid_o (rpt_valid_o),
        .rpt_ready_i (rpt_ready_i),
        .rpt_src_o   (rpt_src_o),
        .rpt_cycle_o (rpt_cycle_o),
        .pend_o      (pend_o),
        .err_cnt_o   (err_cnt_o),
        .ovf_o       (ovf_o),
        .stop_o      (stop_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] src;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        logic [7:0] fire;
        logic [7:0] mask;
        logic [7:0] pend1;
        int         err1;
        bit         valid2;
        int         src2;
        logic [7:0] pend2;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: every consumed report must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && rpt_valid_o && rpt_ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_report", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_src", 32'(rpt_src_o), e.src);
                chk("sb_cycle", 32'(rpt_cycle_o), e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic push(input int s, input int c);
        exp_t e;
        e.src = 32'(s);
        e.cyc = 32'(c);
        q.push_back(e);
    endtask

    // After release the DUT counter reads 0 until the first edge, matching cyc.
    task automatic apply_reset();
        reset       = 1'b1;
        fire_i      = '0;
        mask_i      = '1;
        rpt_ready_i = 1'b1;
        q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{8'h08, 8'hFF, 8'h08, 1, 1'b1, 3, 8'h00};
        vecs[1] = '{8'h25, 8'hFF, 8'h25, 3, 1'b1, 0, 8'h24};
        vecs[2] = '{8'h10, 8'hEF, 8'h00, 0, 1'b0, 0, 8'h00};
        vecs[3] = '{8'hFF, 8'h0F, 8'h0F, 4, 1'b1, 0, 8'h0E};
        vecs[4] = '{8'h80, 8'hFF, 8'h80, 1, 1'b1, 7, 8'h00};
        vecs[5] = '{8'hC0, 8'h40, 8'h40, 1, 1'b1, 6, 8'h00};

        apply_reset();
        chk("rst_valid", 32'(rpt_valid_o), 32'd0);
        chk("rst_pend", 32'(pend_o), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_stop", 32'(stop_o), 32'd0);
        chk("rst_src", 32'(rpt_src_o), 32'd0);
        chk("rst_cycle", 32'(rpt_cycle_o), 32'd0);

        // Single fire of source 3 at cycle 10; first handshake at 12 -> stop at 17.
        go_to(10);
        fire_i = 8'h08;
        push(3, 10);
        tick();
        fire_i = '0;
        chk("s1_pend_c11", 32'(pend_o), 32'h08);
        chk("s1_valid_c11", 32'(rpt_valid_o), 32'd0);
        tick();
        chk("s1_valid_c12", 32'(rpt_valid_o), 32'd1);
        chk("s1_src_c12", 32'(rpt_src_o), 32'd3);
        chk("s1_cycle_c12", 32'(rpt_cycle_o), 32'd10);
        chk("s1_err", 32'(err_cnt_o), 32'd1);
        go_to(16);
        chk("stop_c16", 32'(stop_o), 32'd0);
        tick();
        chk("stop_c17", 32'(stop_o), 32'd1);
        go_to(25);
        chk("stop_sticky", 32'(stop_o), 32'd1);

        // Sources 0,2,5 together -> consecutive reports in round-robin order.
        apply_reset();
        go_to(5);
        fire_i = 8'h25;
        push(0, 5); push(2, 5); push(5, 5);
        tick();
        fire_i = '0;
        chk("s2_pend_c6", 32'(pend_o), 32'h25);
        tick();
        chk("s2_src_c7", 32'(rpt_src_o), 32'd0);
        chk("s2_pend_c7", 32'(pend_o), 32'h24);
        tick();
        chk("s2_src_c8", 32'(rpt_src_o), 32'd2);
        tick();
        chk("s2_src_c9", 32'(rpt_src_o), 32'd5);
        chk("s2_valid_c9", 32'(rpt_valid_o), 32'd1);
        chk("s2_err", 32'(err_cnt_o), 32'd3);
        tick();
        chk("s2_valid_c10", 32'(rpt_valid_o), 32'd0);

        // Vector table: one fire pattern per reset, consumer stalled.
        for (int v = 0; v < 6; v++) begin
            apply_reset();
            rpt_ready_i = 1'b0;
            mask_i      = vecs[v].mask;
            go_to(3);
            fire_i = vecs[v].fire;
            tick();
            fire_i = '0;
            chk($sformatf("v%0d_pend1", v), 32'(pend_o), 32'(vecs[v].pend1));
            chk($sformatf("v%0d_err", v), 32'(err_cnt_o), 32'(vecs[v].err1));
            tick();
            chk($sformatf("v%0d_valid", v), 32'(rpt_valid_o), 32'(vecs[v].valid2));
            chk($sformatf("v%0d_pend2", v), 32'(pend_o), 32'(vecs[v].pend2));
            chk($sformatf("v%0d_ovf", v), 32'(ovf_o), 32'd0);
            if (vecs[v].valid2) begin
                chk($sformatf("v%0d_src", v), 32'(rpt_src_o), 32'(vecs[v].src2));
                chk($sformatf("v%0d_cycle", v), 32'(rpt_cycle_o), 32'd3);
            end
        end

        // Grant-clear and refire of the same source in one cycle: new fire, no overflow.
        apply_reset();
        go_to(3);
        fire_i = 8'h02;
        push(1, 3); push(1, 4);
        tick();
        tick();
        fire_i = '0;
        chk("s3_ovf", 32'(ovf_o), 32'd0);
        chk("s3_err", 32'(err_cnt_o), 32'd2);
        chk("s3_pend", 32'(pend_o), 32'h02);
        tick();
        chk("s3_cycle_c6", 32'(rpt_cycle_o), 32'd4);
        chk("s3_pend_c6", 32'(pend_o), 32'h00);

        // Stalled consumer: payload holds, then a refire on a pending source overflows.
        apply_reset();
        rpt_ready_i = 1'b0;
        go_to(3);
        fire_i = 8'h02;
        push(1, 3);
        tick();
        fire_i = '0;
        tick();
        chk("s4_valid_c5", 32'(rpt_valid_o), 32'd1);
        fire_i = 8'h02;
        push(1, 5);
        tick();
        fire_i = '0;
        chk("s4_pend_c6", 32'(pend_o), 32'h02);
        chk("s4_err_c6", 32'(err_cnt_o), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s4_hold_valid", 32'(rpt_valid_o), 32'd1);
            chk("s4_hold_src", 32'(rpt_src_o), 32'd1);
            chk("s4_hold_cycle", 32'(rpt_cycle_o), 32'd3);
        end
        fire_i = 8'h02;
        tick();
        fire_i = '0;
        chk("s4_ovf", 32'(ovf_o), 32'd1);
        chk("s4_err_keep", 32'(err_cnt_o), 32'd2);
        chk("s4_pend_keep", 32'(pend_o), 32'h02);
        rpt_ready_i = 1'b1;
        tick();
        chk("s4_ts_keep", 32'(rpt_cycle_o), 32'd5);
        tick();
        chk("s4_valid_end", 32'(rpt_valid_o), 32'd0);
        chk("s4_ovf_sticky", 32'(ovf_o), 32'd1);

        // Reset from HALT with a report in flight.
        apply_reset();
        go_to(3);
        fire_i = 8'h04;
        push(2, 3);
        tick();
        fire_i = '0;
        begin
            int budget;
            budget = 0;
            while (!stop_o && budget < 20) begin
                tick();
                budget++;
            end
        end
        chk("s5_stop_reached", 32'(stop_o), 32'd1);
        rpt_ready_i = 1'b0;
        c = cyc;
        fire_i = 8'h10;
        tick();
        fire_i = '0;
        tick();
        chk("s5_valid_before_rst", 32'(rpt_valid_o), 32'd1);
        chk("s5_cycle_before_rst", 32'(rpt_cycle_o), 32'(c));
        #2;
        reset = 1'b1;
        #1;
        chk("s5_async_valid", 32'(rpt_valid_o), 32'd0);
        chk("s5_async_src", 32'(rpt_src_o), 32'd0);
        chk("s5_async_cycle", 32'(rpt_cycle_o), 32'd0);
        chk("s5_async_pend", 32'(pend_o), 32'd0);
        chk("s5_async_err", 32'(err_cnt_o), 32'd0);
        chk("s5_async_ovf", 32'(ovf_o), 32'd0);
        chk("s5_async_stop", 32'(stop_o), 32'd0);
        q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
        rpt_ready_i = 1'b1;
        go_to(2);
        chk("s5_no_reissue", 32'(rpt_valid_o), 32'd0);
        chk("s5_stop_low", 32'(stop_o), 32'd0);
        go_to(3);
        fire_i = 8'h40;
        push(6, 3);
        tick();
        fire_i = '0;
        go_to(9);
        chk("s5_run_stop_c9", 32'(stop_o), 32'd0);
        tick();
        chk("s5_run_stop_c10", 32'(stop_o), 32'd1);

        tick();
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
